// File: rtl/load_store_unit.sv
// Load/store unit: byte lanes, extension, two-beat misaligned split.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SPLIT = 1'b1;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  logic              r_state;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wd_hi;
  logic [3:0]        r_be_hi;
  logic [31:0]       r_lo;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;

  logic              w_idle;
  logic              w_acc;
  logic [1:0]        w_off;
  logic [2:0]        w_sz;
  logic [3:0]        w_bm;
  logic              w_legal;
  logic              w_mis;
  logic              w_split;
  logic              w_err;
  logic [7:0]        w_mask8;
  logic [63:0]       w_wd64;
  logic [31:0]       w_rd_sh;
  logic [5:0]        w_hsh;
  logic [31:0]       w_merge;
  logic [ADDR_W-1:0] w_waddr;

  function automatic logic [31:0] f_ext(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] v;
    case (f3)
      3'b000:  v = {{24{d[7]}}, d[7:0]};
      3'b001:  v = {{16{d[15]}}, d[15:0]};
      3'b100:  v = {24'b0, d[7:0]};
      3'b101:  v = {16'b0, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = w_idle;
  assign w_acc     = req_valid && w_idle && rst;
  assign w_off     = req_addr[1:0];
  assign w_waddr   = {req_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_sz = 3'd4;
    w_bm = 4'b1111;
    unique case (1'b1)
      (req_funct3[1:0] == 2'b00): begin w_sz = 3'd1; w_bm = 4'b0001; end
      (req_funct3[1:0] == 2'b01): begin w_sz = 3'd2; w_bm = 4'b0011; end
      default:                    begin w_sz = 3'd4; w_bm = 4'b1111; end
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !req_we;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_mis   = ({1'b0, w_off} + w_sz) > 3'd4;
  assign w_split = w_legal && w_mis && !TRAP;
  assign w_err   = !w_legal || (w_mis && TRAP);

  // Low nibble/word feeds the first beat, high half the second beat.
  assign w_mask8 = {4'b0000, w_bm} << w_off;
  assign w_wd64  = {32'b0, req_wdata} << {w_off, 3'b000};
  assign w_rd_sh = mem_rd >> {w_off, 3'b000};
  assign w_hsh   = {3'd4 - {1'b0, r_off}, 3'b000};
  assign w_merge = r_lo | (mem_rd << w_hsh);

  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_be   = 4'b0000;
    mem_wd   = 32'b0;
    if (rst) begin
      if (r_state == S_SPLIT) begin
        mem_addr = r_addr + WORD_STEP;
        mem_we   = r_we;
        mem_be   = r_be_hi;
        mem_wd   = r_wd_hi;
      end else if (w_acc && !w_err) begin
        mem_addr = w_waddr;
        mem_we   = req_we;
        mem_be   = w_mask8[3:0];
        mem_wd   = w_wd64[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_f3         <= 3'b000;
      r_off        <= 2'b00;
      r_addr       <= '0;
      r_wd_hi      <= 32'b0;
      r_be_hi      <= 4'b0000;
      r_lo         <= 32'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (r_state == S_SPLIT) begin
        r_state      <= S_IDLE;
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b0;
        r_resp_rdata <= r_we ? 32'b0 : f_ext(r_f3, w_merge);
      end else if (w_acc) begin
        if (w_err) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= 32'b0;
        end else if (w_split) begin
          r_state <= S_SPLIT;
          r_we    <= req_we;
          r_f3    <= req_funct3;
          r_off   <= w_off;
          r_addr  <= w_waddr;
          r_wd_hi <= w_wd64[63:32];
          r_be_hi <= w_mask8[7:4];
          r_lo    <= w_rd_sh;
        end else begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= req_we ? 32'b0 : f_ext(req_funct3, w_rd_sh);
        end
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-word byte-lane memory.
// Memory words are indexed by mem_addr[9:2]; contents preset during reset.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mem_rd = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[255] <= 32'h1200_0000;
      mem[0]   <= 32'h0000_0080;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'h0;
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_we", mem_we, 0);
    @(negedge clk);
    rst = 1'b1;

    drive(1, 3'b010, 32'h100, 32'hDEAD_BEEF);
    chk("sw_be", mem_be, 4'b1111);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_we", mem_we, 1);
    chk("sw_wd", mem_wd, 32'hDEAD_BEEF);
    tick();
    chk("sw_rvalid", resp_valid, 1);
    chk("sw_rdata", resp_rdata, 0);
    chk("idle_addr", mem_addr, 0);

    drive(0, 3'b010, 32'h100, 32'h0);
    chk("lw_we", mem_we, 0);
    tick();
    chk("lw_rvalid", resp_valid, 1);
    chk("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("lw_err", resp_err, 0);
    @(posedge clk);
    #1;
    chk("pulse_once", resp_valid, 0);

    drive(1, 3'b000, 32'h103, 32'h0000_00A5);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wd", mem_wd, 32'hA500_0000);
    tick();
    drive(0, 3'b000, 32'h103, 32'h0);
    tick();
    chk("lb_rdata", resp_rdata, 32'hFFFF_FFA5);
    drive(0, 3'b100, 32'h103, 32'h0);
    tick();
    chk("lbu_rdata", resp_rdata, 32'h0000_00A5);
    drive(0, 3'b001, 32'h102, 32'h0);
    tick();
    chk("lh_al_rdata", resp_rdata, 32'hFFFF_A5AD);

    drive(0, 3'b011, 32'h100, 32'h0);
    chk("ill_ld_be", mem_be, 0);
    chk("ill_ld_we", mem_we, 0);
    tick();
    chk("ill_ld_rv", resp_valid, 1);
    chk("ill_ld_err", resp_err, 1);
    chk("ill_ld_rd", resp_rdata, 0);
    drive(1, 3'b100, 32'h100, 32'hFFFF_FFFF);
    chk("ill_st_be", mem_be, 0);
    chk("ill_st_we", mem_we, 0);
    tick();
    chk("ill_st_rv", resp_valid, 1);
    chk("ill_st_err", resp_err, 1);
    chk("ill_st_rd", resp_rdata, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    drive(1, 3'b010, 32'h101, 32'h1234_5678);
    chk("trap_be", mem_be, 0);
    chk("trap_we", mem_we, 0);
    tick();
    chk("trap_rv", resp_valid, 1);
    chk("trap_err", resp_err, 1);
    chk("trap_rd", resp_rdata, 0);
    chk("trap_ready", req_ready, 1);
`else
    drive(1, 3'b010, 32'h102, 32'h1122_3344);
    chk("msw1_addr", mem_addr, 32'h100);
    chk("msw1_be", mem_be, 4'b1100);
    chk("msw1_wd", mem_wd, 32'h3344_0000);
    chk("msw1_ready", req_ready, 1);
    tick();
    chk("msw2_ready", req_ready, 0);
    chk("msw2_rv", resp_valid, 0);
    chk("msw2_addr", mem_addr, 32'h104);
    chk("msw2_be", mem_be, 4'b0011);
    chk("msw2_wd", mem_wd, 32'h0000_1122);
    chk("msw2_we", mem_we, 1);
    tick();
    chk("msw_rv", resp_valid, 1);
    chk("msw_ready", req_ready, 1);
    chk("msw_err", resp_err, 0);

    drive(0, 3'b010, 32'h102, 32'h0);
    tick();
    chk("mlw_rv1", resp_valid, 0);
    chk("mlw2_be", mem_be, 4'b0011);
    tick();
    chk("mlw_rv2", resp_valid, 1);
    chk("mlw_rdata", resp_rdata, 32'h1122_3344);

    drive(0, 3'b001, 32'hFFFF_FFFF, 32'h0);
    chk("wrap1_addr", mem_addr, 32'hFFFF_FFFC);
    chk("wrap1_be", mem_be, 4'b1000);
    tick();
    chk("wrap2_addr", mem_addr, 32'h0);
    chk("wrap2_be", mem_be, 4'b0001);
    tick();
    chk("wrap_rv", resp_valid, 1);
    chk("wrap_rdata", resp_rdata, 32'hFFFF_8012);

    drive(1, 3'b010, 32'h103, 32'hCAFE_F00D);
    chk("rsp1_be", mem_be, 4'b1000);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b0;
    #1;
    chk("rsp_no_we", mem_we, 0);
    chk("rsp_no_be", mem_be, 0);
    @(posedge clk);
    #1;
    chk("rsp_rv", resp_valid, 0);
    chk("rsp_ready", req_ready, 1);
    chk("rsp_rdata", resp_rdata, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_rv_after", resp_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-organised data memory.
- Accepts one load/store request at a time and generates byte enables and lane-shifted write data.
- Sign/zero-extends load data.
- Splits misaligned halfword/word accesses into two sequential word accesses; stalls the core via req_ready while busy.

Parameters:
ADDR_W, 32, byte-address width on both the core and memory sides.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-low reset (clear when rst==0 at a rising edge of clk)
req_valid  input  1  core presents a memory request
req_ready  output  1  unit can accept a request (state IDLE)
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, LSB-justified
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  extended load data (0 for stores)
resp_err  output  1  valid with resp_valid: illegal funct3
mem_addr  output  ADDR_W  word-aligned address (bits [1:0]=00)
mem_we  output  1  memory write strobe, sampled at rising edge
mem_be  output  4  byte enables, bit i = byte lane i
mem_wd  output  32  lane-positioned write data
mem_rd  input  32  combinational read data for mem_addr

Behaviour:
- States: IDLE, SPLIT. req_ready = (state==IDLE). A request is accepted when req_valid && req_ready.
- Offset o = req_addr[1:0]; size s = 1/2/4 bytes from funct3[1:0].
- Access is misaligned when o+s > 4: H at o=3, or W at o=1..3.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Illegal funct3: no memory strobe (mem_we=0, mem_be=0); next cycle resp_valid=1, resp_err=1, resp_rdata=0.
- Aligned access, accepted in IDLE:
  - mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - mem_be = ((1<<s)-1)<<o.
  - mem_wd = wdata<<(8*o).
  - mem_we = req_we, in the same cycle.
  - Load data from mem_rd is shifted right by 8*o, extended, and registered.
  - resp_valid is asserted the following cycle. Latency 1. State stays IDLE.
- Misaligned access, cycle 1 (IDLE):
  - First word as above; mem_be covers lanes o..3.
  - Latch request fields and the low-part read bytes; go to SPLIT.
- Misaligned access, cycle 2 (SPLIT):
  - mem_addr = first word + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000).
  - mem_be = lanes 0..(o+s-5).
  - mem_wd = wdata>>(8*(4-o)).
  - Merge read bytes and register the result; return to IDLE.
  - resp_valid asserted the next cycle. Latency 2, req_ready low for one cycle.
- Output timing:
  - mem_* outputs are combinational from state and request.
  - In IDLE without an accepted request: mem_we=0, mem_be=0, mem_addr=0, mem_wd=0.
  - Core must hold req_* stable only in the accept cycle; SPLIT uses latched copies.
- Extension:
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W passes through.
  - Stores return resp_rdata=0.
- resp_valid/resp_err/resp_rdata are registered. resp_valid is high exactly one cycle per request. A new request may be accepted in the same cycle resp_valid is high.
- Reset (rst==0): state<=IDLE, resp_valid<=0, resp_err<=0, resp_rdata<=0, latched fields<=0.
- Reset during SPLIT: the second half is not issued and no response is produced. The first-half store already committed is not rolled back.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses are not split. No memory strobe is issued; the next cycle gives resp_valid=1, resp_err=1, resp_rdata=0. State SPLIT is unreachable and may be omitted.
- Undefined: misaligned accesses are split as described; resp_err is set only for illegal funct3.

Test Plan:
- Aligned SW at 0x100 with wdata 0xDEADBEEF, then LW at 0x100:
  - Store cycle: mem_be=1111, mem_addr=0x100.
  - Load response one cycle after accept: resp_rdata=0xDEADBEEF.
- SB at 0x103 with wdata 0x000000A5:
  - mem_be=1000, mem_wd[31:24]=0xA5.
  - LB at 0x103 returns 0xFFFFFFA5; LBU at 0x103 returns 0x000000A5.
- Misaligned SW at 0x102 with wdata 0x11223344:
  - Cycle 1: addr 0x100, be=1100, wd=0x33440000.
  - Cycle 2: addr 0x104, be=0011, wd=0x00001122.
  - req_ready low for one cycle.
  - LW at 0x102 returns 0x11223344 two cycles after accept.
- LH at 0xFFFFFFFF:
  - Second access at mem_addr=0x00000000 with be=0001.
  - Merged result sign-extended correctly (byte 0x80 in the upper lane gives 0xFFFF80xx).
- req_funct3=011 load, and funct3=100 store:
  - mem_be=0000, mem_we=0.
  - resp_valid=1, resp_err=1, resp_rdata=0.
  - With LSU_MISALIGN_TRAP_EN defined, SW at 0x101 also gives resp_err=1.
- Assert rst=0 in the SPLIT cycle of SW at 0x103:
  - No second strobe and no resp_valid.
  - After reset: req_ready=1, resp_valid=0, resp_rdata=0.
